// File: rtl/addsub_hex_pkg.sv
// Shared constants and the hex-to-seven-segment table for the add/subtract display block.
// Segment vectors are ordered {CA,CB,CC,CD,CE,CF,CG} and are active-low.
package addsub_hex_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'b1111111;

  function automatic seg_t hex_to_seg(input logic [3:0] nib);
    seg_t s;
    s = SEG_BLANK;
    case (nib)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      4'hF: s = 7'b0111000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg_scan_driver.sv
// Time-multiplexed seven-segment scanner: prescaler, digit index and registered anode/segment outputs.
// Slots at or beyond NDIG are blanked but keep their share of scan time.
module seg_scan_driver
  import addsub_hex_pkg::*;
#(
  parameter int DIGITS   = 8,
  parameter int SCAN_DIV = 100000,
  parameter int NDIG     = 3
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [4*NDIG-1:0]   r_i,
  output logic [DIGITS-1:0]   an_o,
  output logic [6:0]          seg_o
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [PW-1:0]     presc_q, presc_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [DIGITS-1:0] an_q, an_d;
  seg_t              seg_q, seg_d;
  logic              tick;
  logic [3:0]        nib;

  always_comb begin
    tick    = (presc_q == PW'(SCAN_DIV - 1));
    presc_d = tick ? '0 : presc_q + 1'b1;
    idx_d   = idx_q;
    if (tick) begin
      idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
    nib   = 4'(r_i >> {idx_q, 2'b00});
    an_d  = '1;
    seg_d = SEG_BLANK;
    // Outputs follow the current index, so a tick shows up on the display one clock later.
    if (int'(idx_q) < NDIG) begin
      an_d[idx_q] = 1'b0;
      seg_d       = hex_to_seg(nib);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      presc_q <= '0;
      idx_q   <= '0;
      an_q    <= '1;
      seg_q   <= SEG_BLANK;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign an_o  = an_q;
  assign seg_o = seg_q;

endmodule

// File: rtl/addsub_hex_scan.sv
// Board-level WIDTH-bit unsigned add/subtract of two switch operands, loaded on a BTNC rising edge.
// Result drives the LEDs directly and a multiplexed hex display through seg_scan_driver.
module addsub_hex_scan
  import addsub_hex_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DIGITS   = 8,
  parameter int SCAN_DIV = 100000
) (
  input  logic                 CLK100MHZ,
  input  logic                 RST,
  input  logic [2*WIDTH-1:0]   SW,
  input  logic                 MODE,
  input  logic                 BTNC,
  output logic [WIDTH:0]       LED,
  output logic                 CA,
  output logic                 CB,
  output logic                 CC,
  output logic                 CD,
  output logic                 CE,
  output logic                 CF,
  output logic                 CG,
  output logic                 DP,
  output logic [DIGITS-1:0]    AN
);

  localparam int NDIG = (WIDTH + 4) / 4;
  localparam int RW   = 4 * NDIG;

  logic             sync1_q, sync2_q, prev_q;
  logic             load;
  logic [WIDTH-1:0] op_a, op_b;
  logic [WIDTH:0]   sum, r_q, r_d;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic [RW-1:0]    r_ext;
  seg_t             seg;

  always_ff @(posedge CLK100MHZ or posedge RST) begin
    if (RST) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= BTNC;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign load = sync2_q & ~prev_q;

  assign op_a   = SW[WIDTH-1:0];
  assign op_b   = SW[2*WIDTH-1:WIDTH];
  assign sum    = {1'b0, op_a} + {1'b0, op_b};
  assign diff   = op_a - op_b;
  assign borrow = (op_a < op_b);

  // Switches and MODE are sampled only on the load cycle; otherwise they are ignored.
  always_comb begin
    r_d = r_q;
    if (load) begin
      r_d = (MODE == MODE_SUB) ? {borrow, diff} : sum;
    end
  end

  always_ff @(posedge CLK100MHZ or posedge RST) begin
    if (RST) r_q <= '0;
    else     r_q <= r_d;
  end

  assign r_ext = RW'(r_q);

  seg_scan_driver #(
    .DIGITS   (DIGITS),
    .SCAN_DIV (SCAN_DIV),
    .NDIG     (NDIG)
  ) u_scan (
    .clk_i (CLK100MHZ),
    .rst_i (RST),
    .r_i   (r_ext),
    .an_o  (AN),
    .seg_o (seg)
  );

  assign {CA, CB, CC, CD, CE, CF, CG} = seg;
  assign DP  = 1'b1;
  assign LED = r_q;

endmodule

// File: tb/tb_addsub_hex_scan.sv
// Directed bench for addsub_hex_scan with WIDTH=8, DIGITS=8, SCAN_DIV=4.
module tb_addsub_hex_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] sw;
  logic        mode;
  logic        btnc;
  logic [8:0]  led;
  logic        ca, cb, cc, cd, ce, cf, cg, dp;
  logic [7:0]  an;
  logic [6:0]  seg;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [6:0] S0 = 7'b0000001;
  localparam logic [6:0] S1 = 7'b1001111;
  localparam logic [6:0] S4 = 7'b1001100;
  localparam logic [6:0] S6 = 7'b0100000;
  localparam logic [6:0] S9 = 7'b0000100;
  localparam logic [6:0] SE = 7'b0110000;
  localparam logic [6:0] SF = 7'b0111000;
  localparam logic [6:0] SB = 7'b1111111;

  addsub_hex_scan #(.WIDTH(8), .DIGITS(8), .SCAN_DIV(4)) dut (
    .CLK100MHZ (clk),
    .RST       (rst),
    .SW        (sw),
    .MODE      (mode),
    .BTNC      (btnc),
    .LED       (led),
    .CA        (ca),
    .CB        (cb),
    .CC        (cc),
    .CD        (cd),
    .CE        (ce),
    .CF        (cf),
    .CG        (cg),
    .DP        (dp),
    .AN        (an)
  );

  assign seg = {ca, cb, cc, cd, ce, cf, cg};

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic m, input logic [8:0] old_r, input logic [8:0] exp_r);
    sw   = {b, a};
    mode = m;
    btnc = 1'b1;
    tick();
    tick();
    chk({tag, "_pre"}, 32'(led), 32'(old_r));
    tick();
    chk({tag, "_led"}, 32'(led), 32'(exp_r));
    btnc = 1'b0;
    repeat (3) tick();
  endtask

  task automatic wait_slot0();
    logic [7:0] prev;
    bit         found;
    found = 1'b0;
    for (int i = 0; i < 48 && !found; i++) begin
      prev = an;
      tick();
      if (an == 8'hFE && prev != 8'hFE) found = 1'b1;
    end
    chk("slot0_found", 32'(found), 32'd1);
  endtask

  task automatic scan_check(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                            input logic [6:0] s2);
    wait_slot0();
    chk({tag, "_an0"}, 32'(an), 32'hFE);
    chk({tag, "_seg0"}, 32'(seg), 32'(s0));
    repeat (3) tick();
    chk({tag, "_an0_end"}, 32'(an), 32'hFE);
    tick();
    chk({tag, "_an1"}, 32'(an), 32'hFD);
    chk({tag, "_seg1"}, 32'(seg), 32'(s1));
    repeat (4) tick();
    chk({tag, "_an2"}, 32'(an), 32'hFB);
    chk({tag, "_seg2"}, 32'(seg), 32'(s2));
    for (int k = 3; k < 8; k++) begin
      repeat (4) tick();
      chk($sformatf("%s_an%0d", tag, k), 32'(an), 32'hFF);
      chk($sformatf("%s_seg%0d", tag, k), 32'(seg), 32'(SB));
    end
    repeat (4) tick();
    chk({tag, "_wrap"}, 32'(an), 32'hFE);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst  = 1'b1;
    sw   = '0;
    mode = 1'b0;
    btnc = 1'b0;
    #1;
    chk("rst_led", 32'(led), 32'h0);
    chk("rst_an", 32'(an), 32'hFF);
    chk("rst_seg", 32'(seg), 32'(SB));
    chk("rst_dp", 32'(dp), 32'h1);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("rel_an", 32'(an), 32'hFE);
    chk("rel_seg", 32'(seg), 32'(S0));

    do_load("add_ff_01", 8'hFF, 8'h01, 1'b0, 9'h000, 9'h100);
    scan_check("scan100", S0, S0, S1);

    do_load("sub_05_07", 8'h05, 8'h07, 1'b1, 9'h100, 9'h1FE);
    scan_check("scan1fe", SE, SF, S1);

    do_load("add_80_7f", 8'h80, 8'h7F, 1'b0, 9'h1FE, 9'h0FF);
    do_load("sub_80_01", 8'h80, 8'h01, 1'b1, 9'h0FF, 9'h07F);
    do_load("sub_01_80", 8'h01, 8'h80, 1'b1, 9'h07F, 9'h181);
    do_load("sub_5a_5a", 8'h5A, 8'h5A, 1'b1, 9'h181, 9'h000);

    // Held button: one load at the third edge, later switch activity must not reach R.
    sw   = {8'h34, 8'h12};
    mode = 1'b0;
    btnc = 1'b1;
    tick();
    tick();
    chk("hold_pre", 32'(led), 32'h000);
    tick();
    chk("hold_load", 32'(led), 32'h046);
    for (int i = 0; i < 47; i++) begin
      sw   = {8'(i * 37 + 5), 8'(i * 11 + 3)};
      mode = i[0];
      tick();
    end
    chk("hold_end", 32'(led), 32'h046);
    btnc = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sw = {8'(i * 53), 8'(i * 29 + 1)};
      tick();
    end
    chk("hold_release", 32'(led), 32'h046);

    // Load edge coincides with the slot-0 to slot-1 tick.
    wait_slot0();
    sw   = {8'h0A, 8'h0F};
    mode = 1'b0;
    btnc = 1'b1;
    tick();
    chk("col_an_t1", 32'(an), 32'hFE);
    tick();
    chk("col_led_old", 32'(led), 32'h046);
    chk("col_seg_t2", 32'(seg), 32'(S6));
    tick();
    chk("col_led_new", 32'(led), 32'h019);
    chk("col_an_t3", 32'(an), 32'hFE);
    chk("col_seg_old", 32'(seg), 32'(S6));
    tick();
    chk("col_an_t4", 32'(an), 32'hFD);
    chk("col_seg_new", 32'(seg), 32'(S1));
    btnc = 1'b0;
    scan_check("scan019", S9, S1, S0);

    // Reset while a load is still inside the synchroniser.
    sw   = {8'h22, 8'h11};
    mode = 1'b0;
    btnc = 1'b1;
    tick();
    rst  = 1'b1;
    btnc = 1'b0;
    #1;
    chk("mid_rst_led", 32'(led), 32'h000);
    chk("mid_rst_an", 32'(an), 32'hFF);
    chk("mid_rst_seg", 32'(seg), 32'(SB));
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("rerel_an", 32'(an), 32'hFE);
    chk("rerel_seg", 32'(seg), 32'(S0));
    chk("rerel_led", 32'(led), 32'h000);
    repeat (3) tick();
    chk("rerel_an_e4", 32'(an), 32'hFE);
    tick();
    chk("rerel_an_e5", 32'(an), 32'hFD);
    repeat (3) tick();
    chk("rerel_led_late", 32'(led), 32'h000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  logic unused_s4;
  assign unused_s4 = ^S4;

endmodule
